// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - write-back arbiter bus bundle
//
// Purpose: groups the two producer streams (EXE results, memory loads) and
//          the register-file write port of wb_arbiter into one interface.
// Modports:
//   master - producer / register-file side: drives exe_* and mem_* offers,
//            observes readies, write-back outputs and fifo_count.
//   slave  - the arbiter itself.
// Signals:
//   exe_valid/exe_ready/exe_dest[3:0]/exe_result[31:0]   EXE result stream
//   mem_valid/mem_ready/mem_dest[3:0]/mem_result[31:0]   load response stream
//   write_back_en, dest_wb[3:0], result_wb[31:0]         registered write port
//   fifo_count[$clog2(FIFO_DEPTH):0]                     EXE FIFO occupancy
//   pend_mask[15:0]   only when WB_PEND_MASK_EN is defined
// Optional feature macro: WB_PEND_MASK_EN

interface wb_arbiter_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          exe_valid;
  logic          exe_ready;
  logic [3:0]    exe_dest;
  logic [31:0]   exe_result;
  logic          mem_valid;
  logic          mem_ready;
  logic [3:0]    mem_dest;
  logic [31:0]   mem_result;
  logic          write_back_en;
  logic [3:0]    dest_wb;
  logic [31:0]   result_wb;
  logic [CW-1:0] fifo_count;
`ifdef WB_PEND_MASK_EN
  logic [15:0]   pend_mask;

  modport master (
    output exe_valid, exe_dest, exe_result, mem_valid, mem_dest, mem_result,
    input  exe_ready, mem_ready, write_back_en, dest_wb, result_wb, fifo_count,
    input  pend_mask
  );

  modport slave (
    input  exe_valid, exe_dest, exe_result, mem_valid, mem_dest, mem_result,
    output exe_ready, mem_ready, write_back_en, dest_wb, result_wb, fifo_count,
    output pend_mask
  );
`else
  modport master (
    output exe_valid, exe_dest, exe_result, mem_valid, mem_dest, mem_result,
    input  exe_ready, mem_ready, write_back_en, dest_wb, result_wb, fifo_count
  );

  modport slave (
    input  exe_valid, exe_dest, exe_result, mem_valid, mem_dest, mem_result,
    output exe_ready, mem_ready, write_back_en, dest_wb, result_wb, fifo_count
  );
`endif

endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-back arbiter (EXE FIFO + mem priority)
//
// Purpose: merges the EXE result stream (buffered in a FIFO_DEPTH-entry FIFO)
//          and the memory-load stream onto the single register-file write port.
//          Loads win, except that after STARVE_LIMIT consecutive load grants
//          with EXE work waiting, one FIFO grant is forced.
// Ports:
//   i_clk  - clock, all state on rising edge
//   i_rst  - synchronous active-high reset
//   bus    - wb_arbiter_if.slave (streams, write port, fifo_count, pend_mask)
// Optional feature macro: WB_PEND_MASK_EN (adds bus.pend_mask hazard mask)

module wb_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  wb_arbiter_if.slave   bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]    r_fifo_dest [FIFO_DEPTH];
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [3:0]    r_starve;
  logic          r_wb_en;
  logic [3:0]    r_dest_wb;
  logic [31:0]   r_result_wb;

  logic w_empty;
  logic w_full;
  logic w_force;
  logic w_push;
  logic w_grant_mem;
  logic w_grant_fifo;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_force = (r_starve == 4'(STARVE_LIMIT)) && !w_empty;

  // Readies are held low through reset so no handshake completes on a reset edge.
  assign bus.exe_ready = !i_rst && !w_full;
  assign bus.mem_ready = !i_rst && !w_force;

  assign w_push       = bus.exe_valid && bus.exe_ready;
  assign w_grant_mem  = !i_rst && bus.mem_valid && !w_force;
  // Grant looks only at current occupancy, so a same-cycle push into an
  // empty FIFO is not eligible until the next cycle.
  assign w_grant_fifo = !i_rst && !w_grant_mem && !w_empty;

  // FIFO storage: no reset needed, validity is tracked by r_count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_dest[r_wr_ptr] <= bus.exe_dest;
      r_fifo_data[r_wr_ptr] <= bus.exe_result;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_starve    <= '0;
      r_wb_en     <= 1'b0;
      r_dest_wb   <= '0;
      r_result_wb <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_grant_fifo) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_grant_fifo})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      // Counts load grants only while EXE work is actually waiting.
      if (w_empty || w_grant_fifo) begin
        r_starve <= '0;
      end else if (w_grant_mem && (r_starve != 4'(STARVE_LIMIT))) begin
        r_starve <= r_starve + 4'd1;
      end

      r_wb_en <= w_grant_mem || w_grant_fifo;
      if (w_grant_mem) begin
        r_dest_wb   <= bus.mem_dest;
        r_result_wb <= bus.mem_result;
      end else if (w_grant_fifo) begin
        r_dest_wb   <= r_fifo_dest[r_rd_ptr];
        r_result_wb <= r_fifo_data[r_rd_ptr];
      end
    end
  end

  assign bus.write_back_en = r_wb_en;
  assign bus.dest_wb       = r_dest_wb;
  assign bus.result_wb     = r_result_wb;
  assign bus.fifo_count    = r_count;

`ifdef WB_PEND_MASK_EN
  logic [15:0] w_pend_mask;

  // Walk occupied slots by offset from the read pointer; the slot index wraps
  // naturally in AW bits.
  always_comb begin
    w_pend_mask = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      if (CW'(k) < r_count) begin
        w_pend_mask[r_fifo_dest[r_rd_ptr + AW'(k)]] = 1'b1;
      end
    end
    if (r_wb_en) begin
      w_pend_mask[r_dest_wb] = 1'b1;
    end
  end

  assign bus.pend_mask = w_pend_mask;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter

module tb_wb_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if #(.FIFO_DEPTH(4)) bus ();

  wb_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [35:0] exp_q[$];
  logic [35:0] mon_e;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.exe_valid  = 1'b0;
    bus.exe_dest   = '0;
    bus.exe_result = '0;
    bus.mem_valid  = 1'b0;
    bus.mem_dest   = '0;
    bus.mem_result = '0;
  endtask

  task automatic expect_wb(input logic [3:0] d, input logic [31:0] v);
    exp_q.push_back({d, v});
  endtask

  // Monitor: every register-file write must match the next expected write.
  always @(negedge clk) begin
    if (bus.write_back_en === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got dest=%0d data=%h, expected no write",
                 bus.dest_wb, bus.result_wb);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.dest_wb, bus.result_wb} !== mon_e) begin
          n_fail++;
          $display("FAIL wb_data: got dest=%0d data=%h, expected dest=%0d data=%h",
                   bus.dest_wb, bus.result_wb, mon_e[35:32], mon_e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int mi;
    int ei;
    bit mem_acc;
    bit exe_acc;
    int guard;

    // Reset state
    rst = 1'b1;
    idle();
    step();
    step();
    check("rst_fifo_count", 36'(bus.fifo_count), 36'd0);
    check("rst_wb_en", 36'(bus.write_back_en), 36'd0);
    check("rst_dest_wb", 36'(bus.dest_wb), 36'd0);
    check("rst_result_wb", 36'(bus.result_wb), 36'd0);
    check("rst_exe_ready", 36'(bus.exe_ready), 36'd0);
    check("rst_mem_ready", 36'(bus.mem_ready), 36'd0);
    rst = 1'b0;
    step();
    check("post_rst_exe_ready", 36'(bus.exe_ready), 36'd1);
    check("post_rst_mem_ready", 36'(bus.mem_ready), 36'd1);

    // Single EXE write: two-cycle latency, one cycle of write enable
    expect_wb(4'd5, 32'hDEADBEEF);
    bus.exe_valid  = 1'b1;
    bus.exe_dest   = 4'd5;
    bus.exe_result = 32'hDEADBEEF;
    step();
    idle();
    check("single_c1_wb_en", 36'(bus.write_back_en), 36'd0);
    check("single_c1_count", 36'(bus.fifo_count), 36'd1);
    step();
    check("single_c2_wb_en", 36'(bus.write_back_en), 36'd1);
    check("single_c2_dest", 36'(bus.dest_wb), 36'd5);
    step();
    check("single_c3_wb_en", 36'(bus.write_back_en), 36'd0);
    check("single_c3_count", 36'(bus.fifo_count), 36'd0);
    step();

    // Mem priority over FIFO head
    expect_wb(4'd3, 32'h11);
    expect_wb(4'd7, 32'h77);
    bus.exe_valid  = 1'b1;
    bus.exe_dest   = 4'd7;
    bus.exe_result = 32'h77;
    step();
    idle();
    bus.mem_valid  = 1'b1;
    bus.mem_dest   = 4'd3;
    bus.mem_result = 32'h11;
    check("prio_mem_ready", 36'(bus.mem_ready), 36'd1);
    step();
    idle();
    check("prio_first_dest", 36'(bus.dest_wb), 36'd3);
    check("prio_count_held", 36'(bus.fifo_count), 36'd1);
    step();
    check("prio_second_dest", 36'(bus.dest_wb), 36'd7);
    check("prio_count_empty", 36'(bus.fifo_count), 36'd0);
    step();

    // Starvation: 3 mem grants, then one forced FIFO grant
    expect_wb(4'd1, 32'd101);
    expect_wb(4'd2, 32'd102);
    expect_wb(4'd3, 32'd103);
    expect_wb(4'd9, 32'd99);
    expect_wb(4'd4, 32'd104);
    bus.exe_valid  = 1'b1;
    bus.exe_dest   = 4'd9;
    bus.exe_result = 32'd99;
    step();
    idle();
    for (int i = 1; i <= 3; i++) begin
      bus.mem_valid  = 1'b1;
      bus.mem_dest   = 4'(i);
      bus.mem_result = 32'(100 + i);
      check($sformatf("starve_mem_ready_%0d", i), 36'(bus.mem_ready), 36'd1);
      step();
    end
    bus.mem_dest   = 4'd4;
    bus.mem_result = 32'd104;
    check("starve_force_ready", 36'(bus.mem_ready), 36'd0);
    check("starve_force_count", 36'(bus.fifo_count), 36'd1);
    step();
    check("starve_resume_ready", 36'(bus.mem_ready), 36'd1);
    check("starve_fifo_dest", 36'(bus.dest_wb), 36'd9);
    step();
    idle();
    check("starve_resume_dest", 36'(bus.dest_wb), 36'd4);
    step();

    // Full FIFO with mem saturated
    for (int k = 0; k < 4; k++) expect_wb(4'(k), 32'h200 + 32'(k));
    expect_wb(4'd10, 32'h300);
    for (int k = 4; k < 7; k++) expect_wb(4'(k), 32'h200 + 32'(k));
    for (int k = 1; k < 5; k++) expect_wb(4'(10 + k), 32'h300 + 32'(k));
    mi = 0;
    ei = 0;
    for (int c = 0; c < 9; c++) begin
      bus.mem_valid  = 1'b1;
      bus.mem_dest   = 4'(mi);
      bus.mem_result = 32'h200 + 32'(mi);
      bus.exe_valid  = (ei < 5);
      bus.exe_dest   = 4'(10 + ei);
      bus.exe_result = 32'h300 + 32'(ei);
      if (c == 4) begin
        check("full_exe_ready_low", 36'(bus.exe_ready), 36'd0);
        check("full_mem_ready_low", 36'(bus.mem_ready), 36'd0);
        check("full_count", 36'(bus.fifo_count), 36'd4);
      end
      if (c == 5) begin
        check("full_exe_ready_back", 36'(bus.exe_ready), 36'd1);
        check("full_count_after_pop", 36'(bus.fifo_count), 36'd3);
      end
      if (c == 8) check("full_second_force", 36'(bus.mem_ready), 36'd0);
      mem_acc = bus.mem_valid && bus.mem_ready;
      exe_acc = bus.exe_valid && bus.exe_ready;
      step();
      if (mem_acc) mi++;
      if (exe_acc) ei++;
    end
    idle();
    check("full_exe_accepted", 36'(ei), 36'd5);
    check("full_mem_accepted", 36'(mi), 36'd7);
    guard = 0;
    while (bus.fifo_count != 0 && guard < 20) begin
      step();
      guard++;
    end
    check("full_drain_timeout", 36'(guard < 20), 36'd1);
    step();
    step();

    // Reset mid-traffic: 3 buffered EXE entries must never be written
    for (int c = 0; c < 3; c++) begin
      expect_wb(4'(12 + c), 32'h400 + 32'(c));
      bus.mem_valid  = 1'b1;
      bus.mem_dest   = 4'(12 + c);
      bus.mem_result = 32'h400 + 32'(c);
      bus.exe_valid  = 1'b1;
      bus.exe_dest   = 4'd6;
      bus.exe_result = 32'h500 + 32'(c);
      step();
    end
    check("rstmid_count_before", 36'(bus.fifo_count), 36'd3);
    rst = 1'b1;
    step();
    check("rstmid_count", 36'(bus.fifo_count), 36'd0);
    check("rstmid_wb_en", 36'(bus.write_back_en), 36'd0);
    check("rstmid_exe_ready", 36'(bus.exe_ready), 36'd0);
    check("rstmid_mem_ready", 36'(bus.mem_ready), 36'd0);
    rst = 1'b0;
    idle();
    for (int c = 0; c < 6; c++) step();
    check("rstmid_count_after", 36'(bus.fifo_count), 36'd0);

`ifdef WB_PEND_MASK_EN
    expect_wb(4'd2, 32'h22);
    expect_wb(4'd9, 32'h99);
    check("pend_idle", 36'(bus.pend_mask), 36'h0000);
    bus.exe_valid  = 1'b1;
    bus.exe_dest   = 4'd2;
    bus.exe_result = 32'h22;
    step();
    check("pend_one", 36'(bus.pend_mask), 36'h0004);
    bus.exe_dest   = 4'd9;
    bus.exe_result = 32'h99;
    step();
    idle();
    check("pend_both", 36'(bus.pend_mask), 36'h0204);
    step();
    check("pend_last", 36'(bus.pend_mask), 36'h0200);
    step();
    check("pend_clear", 36'(bus.pend_mask), 36'h0000);
    step();
`endif

    step();
    check("scoreboard_drained", 36'(exp_q.size()), 36'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writer-side front end for the 16x32 register file's single write-back port. It drives dest_wb / result_wb / write_back_en.
- Merges two producers: the EXE-stage result stream and the memory-load response stream.
- EXE results are buffered in a small FIFO.
- Memory responses have priority, limited by an anti-starvation counter.
- Output is registered, so the register file sees one clean write per cycle at most.

Parameters:
- FIFO_DEPTH, 4, number of EXE entries buffered; power of 2, minimum 2.
- STARVE_LIMIT, 3, number of consecutive mem grants allowed while the FIFO is non-empty before one FIFO grant is forced; range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- exe_valid  input  1  EXE result offered.
- exe_ready  output  1  EXE result accepted when exe_valid && exe_ready.
- exe_dest  input  4  EXE destination register.
- exe_result  input  32  EXE result data.
- mem_valid  input  1  load data offered.
- mem_ready  output  1  load data accepted when mem_valid && mem_ready.
- mem_dest  input  4  load destination register.
- mem_result  input  32  load data.
- write_back_en  output  1  register file write enable, registered.
- dest_wb  output  4  register file write address, registered.
- result_wb  output  32  register file write data, registered.
- fifo_count  output  log2(FIFO_DEPTH)+1  current number of FIFO entries.

Behaviour:
- Reset (synchronous, active-high), on the edge with rst=1:
  - FIFO emptied; read and write pointers = 0; fifo_count = 0.
  - Starvation counter = 0.
  - write_back_en = 0, dest_wb = 0, result_wb = 0.
  - Any in-flight handshake on that edge is discarded; no write is issued for it.
  - While rst is held, exe_ready = 0 and mem_ready = 0.
- exe_ready = !full. There is no pass-through when full: a pop does not free space in the same cycle.
- EXE push: on exe_valid && exe_ready, {exe_dest, exe_result} is written at the write pointer; the pointer wraps modulo FIFO_DEPTH.
- Grant per cycle, combinational from current state:
  - force = (starve_cnt == STARVE_LIMIT) && !empty.
  - mem_ready = !force.
  - If mem_valid && !force: grant mem.
  - Else if !empty: grant FIFO head (pop).
  - Else: no grant.
- Starvation counter:
  - Increments on a mem grant while the FIFO is non-empty.
  - Clears on any FIFO grant, and whenever the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Output register, on each edge:
  - write_back_en <= (grant occurred).
  - dest_wb / result_wb <= granted entry's fields.
  - With no grant, dest_wb and result_wb hold their previous values and write_back_en = 0.
- Latency:
  - Mem accepted at edge E → write_back_en = 1 in the cycle after E.
  - EXE accepted at edge E with empty FIFO and no mem traffic → pop granted in cycle after E → write_back_en = 1 in the cycle after E+1 (2 cycles).
- Simultaneous push and pop with the FIFO non-full: both occur; count unchanged.
- Push into an empty FIFO is not visible to the grant until the next cycle.
- Ordering:
  - FIFO entries are written strictly in arrival order.
  - No reordering between same-dest entries inside the FIFO.
  - Mem and EXE interleave purely per the grant rules above.
- Throughput: at most one write per cycle; with both sources saturated, a sustained pattern of STARVE_LIMIT mem writes then 1 EXE write.

Optional Feature:
- Macro: WB_PEND_MASK_EN.
- Defined: adds output pend_mask[15:0], combinational. Bit i = 1 if any valid FIFO entry has dest == i, or if write_back_en && dest_wb == i. Used by hazard logic to stall readers of in-flight registers. Reset value 0.
- Undefined: the port is absent and there is no logic for it.

Test Plan:
- Reset mid-traffic: fill FIFO with 3 entries, assert rst for 1 cycle → fifo_count = 0, write_back_en = 0 the next cycle, and none of the 3 entries is ever written.
- Single EXE write: exe_dest = 5, exe_result = 32'hDEADBEEF accepted at edge 0 → write_back_en = 1, dest_wb = 5, result_wb = 32'hDEADBEEF during cycle 2 only.
- Mem priority: mem_valid with dest = 3, data = 32'h11, same cycle as FIFO head dest = 7 → R3 written first, R7 the following cycle.
- Starvation: FIFO holds 1 entry, mem_valid held high, STARVE_LIMIT = 3 → 3 mem writes, then mem_ready = 0 for one cycle and the FIFO entry is written, then mem resumes.
- Full FIFO: 4 back-to-back EXE pushes while mem is saturated → exe_ready = 0 after the 4th; a 5th offer is held until a pop, then accepted the following cycle.
- WB_PEND_MASK_EN: push dest = 2 and dest = 9 → pend_mask = 16'h0204; after both are written, pend_mask = 16'h0000.
